// File: rtl/carfield_apb_sequencer.sv
// Carfield peripheral APB sequencer: one request at a time, decoded onto
// five APB slaves, with a per-access timeout for hung slaves.
module carfield_apb_sequencer #(
  parameter int unsigned NumApbSlv     = 5,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 255,
  parameter int unsigned ErrCntWidth   = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [AddrWidth-1:0]           req_addr_i,
  input  logic                           req_write_i,
  input  logic [DataWidth-1:0]           req_wdata_i,
  input  logic [DataWidth/8-1:0]         req_wstrb_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [DataWidth-1:0]           rsp_rdata_o,
  output logic                           rsp_error_o,
  output logic                           rsp_timeout_o,
  output logic [AddrWidth-1:0]           paddr_o,
  output logic [NumApbSlv-1:0]           psel_o,
  output logic                           penable_o,
  output logic                           pwrite_o,
  output logic [DataWidth-1:0]           pwdata_o,
  output logic [DataWidth/8-1:0]         pstrb_o,
  input  logic [NumApbSlv*DataWidth-1:0] prdata_i,
  input  logic [NumApbSlv-1:0]           pready_i,
  input  logic [NumApbSlv-1:0]           pslverr_i,
  output logic [ErrCntWidth-1:0]         timeout_cnt_o
);

  localparam int unsigned IdxWidth =
    (NumApbSlv > 1) ? $clog2(NumApbSlv) : 1;
  localparam int unsigned MapSize = 5;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  localparam logic [8:0] WaitLimit = 9'(TimeoutCycles);

  // Slave order: SystemTimer, AdvancedTimer, SystemWdt, Can, HyperBus
  localparam logic [MapSize-1:0][31:0] SlvBase = {
    32'h2000_9000,
    32'h2000_1000,
    32'h2000_7000,
    32'h2000_5000,
    32'h2000_4000
  };

  logic [1:0]          state;
  logic [IdxWidth-1:0] idxQ;
  logic [8:0]          waitCnt;

  logic                decHit;
  logic [IdxWidth-1:0] decIdx;
  logic [63:0]         addrExt;
  logic [63:0]         baseExt;

  logic [DataWidth-1:0] slvRdata [NumApbSlv];
  logic                 selReady;
  logic                 selErr;
  logic [DataWidth-1:0] selRdata;

  always_comb begin
    decHit  = 1'b0;
    decIdx  = '0;
    baseExt = '0;
    addrExt = 64'(req_addr_i);
    for (int k = 0; k < MapSize; k++) begin
      baseExt = 64'(SlvBase[k]);
      if (k < NumApbSlv && !decHit &&
          addrExt >= baseExt &&
          addrExt < baseExt + 64'h1000) begin
        decHit = 1'b1;
        decIdx = IdxWidth'(k);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NumApbSlv; k++) begin
      slvRdata[k] = prdata_i[k*DataWidth +: DataWidth];
    end
  end

  // Only the addressed slave's handshake is observed
  assign selReady = pready_i[idxQ];
  assign selErr   = pslverr_i[idxQ];
  assign selRdata = slvRdata[idxQ];

  always_comb begin
    psel_o = '0;
    if (state == StSetup || state == StAccess) begin
      psel_o[idxQ] = 1'b1;
    end
  end

  assign penable_o   = (state == StAccess);
  assign req_ready_o = (state == StIdle);
  assign rsp_valid_o = (state == StResp);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= StIdle;
      idxQ          <= '0;
      waitCnt       <= '0;
      paddr_o       <= '0;
      pwrite_o      <= 1'b0;
      pwdata_o      <= '0;
      pstrb_o       <= '0;
      rsp_rdata_o   <= '0;
      rsp_error_o   <= 1'b0;
      rsp_timeout_o <= 1'b0;
      timeout_cnt_o <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req_valid_i) begin
            paddr_o  <= req_addr_i;
            pwrite_o <= req_write_i;
            pwdata_o <= req_wdata_i;
            pstrb_o  <= req_write_i ? req_wstrb_i : '0;
            idxQ     <= decIdx;
            if (decHit) begin
              state <= StSetup;
            end else begin
              state         <= StResp;
              rsp_rdata_o   <= '0;
              rsp_error_o   <= 1'b1;
              rsp_timeout_o <= 1'b0;
            end
          end
        end
        StSetup: begin
          waitCnt <= '0;
          state   <= StAccess;
        end
        StAccess: begin
          // A ready on the final allowed cycle still completes normally
          if (selReady) begin
            state         <= StResp;
            rsp_error_o   <= selErr;
            rsp_timeout_o <= 1'b0;
            rsp_rdata_o   <= (pwrite_o || selErr) ? '0 : selRdata;
          end else if (waitCnt + 9'd1 == WaitLimit) begin
            state         <= StResp;
            rsp_error_o   <= 1'b1;
            rsp_timeout_o <= 1'b1;
            rsp_rdata_o   <= '0;
            if (timeout_cnt_o != '1) begin
              timeout_cnt_o <= timeout_cnt_o + 1'b1;
            end
          end else begin
            waitCnt <= waitCnt + 9'd1;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            state         <= StIdle;
            rsp_rdata_o   <= '0;
            rsp_error_o   <= 1'b0;
            rsp_timeout_o <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_carfield_apb_sequencer.sv
// Randomized self-checking bench for carfield_apb_sequencer against a
// transaction-level model of the address map, latency and timeout rules.
module tb_carfield_apb_sequencer;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid_o;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_error_o;
  logic        rsp_timeout_o;
  logic [31:0] paddr_o;
  logic [4:0]  psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [159:0] prdata = '0;
  logic [4:0]  pready = '0;
  logic [4:0]  pslverr = '0;
  logic [7:0]  timeout_cnt_o;

  carfield_apb_sequencer #(
    .NumApbSlv(5), .AddrWidth(32), .DataWidth(32),
    .TimeoutCycles(T), .ErrCntWidth(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr), .req_write_i(req_write),
    .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
    .rsp_timeout_o(rsp_timeout_o),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr),
    .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass = 0;
  int modelTo = 0;

  int          obsCyc;
  int          obsAcc;
  logic [31:0] obsRdata;
  logic        obsErr;
  logic        obsTmo;
  logic [4:0]  obsSel;
  logic [31:0] obsPaddr;
  logic        obsPwrite;
  logic [31:0] obsPwdata;
  logic [3:0]  obsPstrb;
  logic        obsApbChg;
  logic        obsHoldOk;
  logic        obsReady0;
  logic        obsReadyAfter;
  logic        obsValidAfter;

  int          eCyc;
  int          eAcc;
  logic        eErr;
  logic        eTmo;
  logic [31:0] eRd;
  logic [4:0]  eSel;

  function automatic int decodeIdx(input logic [31:0] a);
    case (a[31:12])
      20'h20004: return 0;
      20'h20005: return 1;
      20'h20007: return 2;
      20'h20001: return 3;
      20'h20009: return 4;
      default:   return -1;
    endcase
  endfunction

  task automatic model(input logic [31:0] addr, input logic wr,
                       input int delay, input logic serr,
                       input logic [31:0] rd);
    int s;
    s = decodeIdx(addr);
    if (s < 0) begin
      eCyc = 1; eAcc = 0; eErr = 1'b1; eTmo = 1'b0;
      eRd = '0; eSel = '0;
    end else begin
      eSel = 5'(1 << s);
      if (delay < 0 || delay >= T) begin
        eCyc = 2 + T; eAcc = T; eErr = 1'b1; eTmo = 1'b1; eRd = '0;
        modelTo = (modelTo < 255) ? modelTo + 1 : 255;
      end else begin
        eCyc = 3 + delay; eAcc = delay + 1; eErr = serr; eTmo = 1'b0;
        eRd = (wr || serr) ? 32'h0 : rd;
      end
    end
  endtask

  task automatic drive_slaves(input int sel, input int c, input int delay,
                              input logic serr, input logic [31:0] rd);
    for (int k = 0; k < 5; k++) begin
      if (k == sel) begin
        pready[k] = (delay >= 0 && c >= 2 + delay);
        pslverr[k] = serr;
        prdata[k*32 +: 32] = rd;
      end else begin
        pready[k] = 1'($urandom);
        pslverr[k] = 1'($urandom);
        prdata[k*32 +: 32] = $urandom;
      end
    end
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic wr,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input int delay, input logic serr,
                         input logic [31:0] rd, input int hold);
    int sel;
    bit first;
    sel = decodeIdx(addr);
    first = 0;
    obsCyc = -1; obsAcc = 0; obsSel = '0; obsApbChg = 1'b0;
    obsRdata = 'x; obsErr = 1'bx; obsTmo = 1'bx;
    obsPaddr = 'x; obsPwrite = 1'bx; obsPwdata = 'x; obsPstrb = 'x;
    obsHoldOk = 1'b0; obsReadyAfter = 1'b0; obsValidAfter = 1'b1;
    req_addr = addr; req_write = wr; req_wdata = wd; req_wstrb = ws;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    obsReady0 = req_ready_o;
    drive_slaves(sel, 0, delay, serr, rd);
    for (int c = 1; c < 2 + T + 20; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr = $urandom; req_wdata = $urandom;
      req_wstrb = 4'($urandom); req_write = 1'($urandom);
      drive_slaves(sel, c, delay, serr, rd);
      if (psel_o != '0) begin
        obsSel |= psel_o;
        if (!first) begin
          first = 1;
          obsPaddr = paddr_o; obsPwrite = pwrite_o;
          obsPwdata = pwdata_o; obsPstrb = pstrb_o;
        end else if (paddr_o !== obsPaddr || pwrite_o !== obsPwrite ||
                     pwdata_o !== obsPwdata || pstrb_o !== obsPstrb) begin
          obsApbChg = 1'b1;
        end
      end
      if (penable_o) obsAcc++;
      if (rsp_valid_o) begin
        obsCyc = c;
        obsRdata = rsp_rdata_o; obsErr = rsp_error_o;
        obsTmo = rsp_timeout_o;
        break;
      end
    end
    if (obsCyc < 0) return;
    obsHoldOk = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      drive_slaves(sel, 0, -1, 1'b0, 32'h0);
      if (!rsp_valid_o || req_ready_o || psel_o != '0 ||
          rsp_rdata_o !== obsRdata || rsp_error_o !== obsErr ||
          rsp_timeout_o !== obsTmo) obsHoldOk = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    obsReadyAfter = req_ready_o;
    obsValidAfter = rsp_valid_o;
  endtask

  task automatic test_reset;
    nChecks++; if (req_ready_o !== 1'b1) $display("FAIL rst_req_ready got %b exp 1", req_ready_o); else nPass++;
    nChecks++; if (rsp_valid_o !== 1'b0) $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid_o); else nPass++;
    nChecks++; if (psel_o !== 5'b0) $display("FAIL rst_psel got %b exp 0", psel_o); else nPass++;
    nChecks++; if (penable_o !== 1'b0) $display("FAIL rst_penable got %b exp 0", penable_o); else nPass++;
    nChecks++; if (paddr_o !== 32'h0 || pwdata_o !== 32'h0) $display("FAIL rst_apb_bus got %h/%h exp 0/0", paddr_o, pwdata_o); else nPass++;
    nChecks++; if (pwrite_o !== 1'b0 || pstrb_o !== 4'h0) $display("FAIL rst_pwrite_pstrb got %b/%h exp 0/0", pwrite_o, pstrb_o); else nPass++;
    nChecks++; if (rsp_rdata_o !== 32'h0 || rsp_error_o !== 1'b0 || rsp_timeout_o !== 1'b0) $display("FAIL rst_rsp_fields got %h/%b/%b exp 0", rsp_rdata_o, rsp_error_o, rsp_timeout_o); else nPass++;
    nChecks++; if (timeout_cnt_o !== 8'h0) $display("FAIL rst_timeout_cnt got %0d exp 0", timeout_cnt_o); else nPass++;
  endtask

  task automatic test_read_zero_wait;
    model(32'h2000_5010, 1'b0, 0, 1'b0, 32'hDEAD_BEEF);
    run_txn(32'h2000_5010, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'hDEAD_BEEF, 0);
    nChecks++; if (obsReady0 !== 1'b1) $display("FAIL rd_accept got %b exp 1", obsReady0); else nPass++;
    nChecks++; if (obsSel !== 5'b00010) $display("FAIL rd_psel got %b exp 00010", obsSel); else nPass++;
    nChecks++; if (obsCyc !== eCyc) $display("FAIL rd_latency got %0d exp %0d", obsCyc, eCyc); else nPass++;
    nChecks++; if (obsRdata !== eRd || obsErr !== 1'b0) $display("FAIL rd_data got %h/%b exp %h/0", obsRdata, obsErr, eRd); else nPass++;
    nChecks++; if (obsPaddr !== 32'h2000_5010 || obsPwrite !== 1'b0 || obsPstrb !== 4'h0) $display("FAIL rd_apb got %h/%b/%h exp 20005010/0/0", obsPaddr, obsPwrite, obsPstrb); else nPass++;
    nChecks++; if (obsReadyAfter !== 1'b1 || obsValidAfter !== 1'b0) $display("FAIL rd_back_to_idle got %b/%b exp 1/0", obsReadyAfter, obsValidAfter); else nPass++;
  endtask

  task automatic test_write_wait;
    model(32'h2000_9004, 1'b1, 3, 1'b0, 32'hCAFE_F00D);
    run_txn(32'h2000_9004, 1'b1, 32'h1234_5678, 4'b0011, 3, 1'b0, 32'hCAFE_F00D, 0);
    nChecks++; if (obsSel !== 5'b10000) $display("FAIL wr_psel got %b exp 10000", obsSel); else nPass++;
    nChecks++; if (obsCyc !== 6 || obsCyc !== eCyc) $display("FAIL wr_latency got %0d exp %0d", obsCyc, eCyc); else nPass++;
    nChecks++; if (obsAcc !== 4) $display("FAIL wr_access_cycles got %0d exp 4", obsAcc); else nPass++;
    nChecks++; if (obsApbChg !== 1'b0) $display("FAIL wr_apb_stable got %b exp 0", obsApbChg); else nPass++;
    nChecks++; if (obsPwdata !== 32'h1234_5678 || obsPstrb !== 4'b0011 || obsPwrite !== 1'b1) $display("FAIL wr_apb got %h/%h/%b exp 12345678/3/1", obsPwdata, obsPstrb, obsPwrite); else nPass++;
    nChecks++; if (obsRdata !== 32'h0 || obsErr !== 1'b0 || obsTmo !== 1'b0) $display("FAIL wr_rsp_pready_wins got %h/%b/%b exp 0/0/0", obsRdata, obsErr, obsTmo); else nPass++;
  endtask

  task automatic test_unmapped;
    model(32'h2000_3000, 1'b0, 0, 1'b0, 32'h5555_AAAA);
    run_txn(32'h2000_3000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h5555_AAAA, 1);
    nChecks++; if (obsSel !== 5'b0) $display("FAIL unm_psel got %b exp 0", obsSel); else nPass++;
    nChecks++; if (obsCyc !== eCyc) $display("FAIL unm_latency got %0d exp %0d", obsCyc, eCyc); else nPass++;
    nChecks++; if (obsErr !== 1'b1 || obsTmo !== 1'b0 || obsRdata !== 32'h0) $display("FAIL unm_rsp got %b/%b/%h exp 1/0/0", obsErr, obsTmo, obsRdata); else nPass++;
  endtask

  task automatic test_slverr_hold;
    model(32'h2000_1ABC, 1'b0, 0, 1'b1, 32'h0BAD_0BAD);
    run_txn(32'h2000_1ABC, 1'b0, 32'h0, 4'hF, 0, 1'b1, 32'h0BAD_0BAD, 5);
    nChecks++; if (obsSel !== 5'b01000) $display("FAIL err_psel got %b exp 01000", obsSel); else nPass++;
    nChecks++; if (obsErr !== 1'b1 || obsTmo !== 1'b0) $display("FAIL err_rsp got %b/%b exp 1/0", obsErr, obsTmo); else nPass++;
    nChecks++; if (obsRdata !== eRd) $display("FAIL err_rdata got %h exp %h", obsRdata, eRd); else nPass++;
    nChecks++; if (obsCyc !== eCyc) $display("FAIL err_latency got %0d exp %0d", obsCyc, eCyc); else nPass++;
    nChecks++; if (obsHoldOk !== 1'b1) $display("FAIL err_hold_stable got %b exp 1", obsHoldOk); else nPass++;
    nChecks++; if (obsReadyAfter !== 1'b1) $display("FAIL err_release got %b exp 1", obsReadyAfter); else nPass++;
  endtask

  task automatic test_random;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  ws;
    logic        wr;
    logic        serr;
    int          delay;
    int          hold;
    int          s;
    int          nib;
    logic [3:0]  nibs [9] = '{4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
    for (int i = 0; i < 40; i++) begin
      nib = $urandom_range(0, 8);
      addr = {12'h200, 4'h0, nibs[nib], 12'($urandom)};
      if ($urandom_range(0, 7) == 0) addr = $urandom;
      wr = 1'($urandom); serr = 1'($urandom);
      wd = $urandom; rd = $urandom; ws = 4'($urandom);
      delay = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 5));
      hold = $urandom_range(0, 3);
      s = decodeIdx(addr);
      model(addr, wr, delay, serr, rd);
      run_txn(addr, wr, wd, ws, delay, serr, rd, hold);
      nChecks++; if (obsCyc !== eCyc) $display("FAIL rnd%0d_latency addr %h got %0d exp %0d", i, addr, obsCyc, eCyc); else nPass++;
      nChecks++; if (obsSel !== eSel || obsAcc !== eAcc) $display("FAIL rnd%0d_psel got %b/%0d exp %b/%0d", i, obsSel, obsAcc, eSel, eAcc); else nPass++;
      nChecks++; if (obsRdata !== eRd || obsErr !== eErr || obsTmo !== eTmo) $display("FAIL rnd%0d_rsp got %h/%b/%b exp %h/%b/%b", i, obsRdata, obsErr, obsTmo, eRd, eErr, eTmo); else nPass++;
      if (s >= 0) begin
        nChecks++; if (obsPaddr !== addr || obsPwrite !== wr || obsPwdata !== wd || obsPstrb !== (wr ? ws : 4'h0) || obsApbChg !== 1'b0) $display("FAIL rnd%0d_apb got %h/%b/%h/%h/%b exp %h/%b/%h/%h/0", i, obsPaddr, obsPwrite, obsPwdata, obsPstrb, obsApbChg, addr, wr, wd, wr ? ws : 4'h0); else nPass++;
      end
      nChecks++; if (obsHoldOk !== 1'b1 || obsReadyAfter !== 1'b1) $display("FAIL rnd%0d_handshake got %b/%b exp 1/1", i, obsHoldOk, obsReadyAfter); else nPass++;
      nChecks++; if (int'(timeout_cnt_o) !== modelTo) $display("FAIL rnd%0d_timeout_cnt got %0d exp %0d", i, timeout_cnt_o, modelTo); else nPass++;
    end
  endtask

  task automatic test_timeout;
    int base;
    base = modelTo;
    model(32'h2000_7FFC, 1'b0, -1, 1'b0, 32'h1111_2222);
    run_txn(32'h2000_7FFC, 1'b0, 32'h0, 4'hF, -1, 1'b0, 32'h1111_2222, 0);
    nChecks++; if (obsSel !== 5'b00100) $display("FAIL to_psel got %b exp 00100", obsSel); else nPass++;
    nChecks++; if (obsCyc !== 2 + T) $display("FAIL to_latency got %0d exp %0d", obsCyc, 2 + T); else nPass++;
    nChecks++; if (obsAcc !== T) $display("FAIL to_access_cycles got %0d exp %0d", obsAcc, T); else nPass++;
    nChecks++; if (obsErr !== 1'b1 || obsTmo !== 1'b1 || obsRdata !== 32'h0) $display("FAIL to_rsp got %b/%b/%h exp 1/1/0", obsErr, obsTmo, obsRdata); else nPass++;
    nChecks++; if (int'(timeout_cnt_o) !== base + 1) $display("FAIL to_cnt_inc got %0d exp %0d", timeout_cnt_o, base + 1); else nPass++;
  endtask

  task automatic test_timeout_saturate;
    for (int i = 0; i < 300; i++) begin
      model(32'h2000_7000, 1'b0, -1, 1'b0, 32'h0);
      run_txn(32'h2000_7000, 1'b0, 32'h0, 4'h0, -1, 1'b0, 32'h0, 0);
      if (i == 100) begin
        nChecks++; if (int'(timeout_cnt_o) !== modelTo) $display("FAIL sat_mid got %0d exp %0d", timeout_cnt_o, modelTo); else nPass++;
      end
    end
    nChecks++; if (timeout_cnt_o !== 8'd255 || modelTo !== 255) $display("FAIL sat_final got %0d exp 255", timeout_cnt_o); else nPass++;
    nChecks++; if (obsTmo !== 1'b1) $display("FAIL sat_last_tmo got %b exp 1", obsTmo); else nPass++;
  endtask

  task automatic test_reset_mid;
    bit sawValid;
    req_addr = 32'h2000_4100; req_write = 1'b0; req_valid = 1'b1;
    drive_slaves(0, 0, -1, 1'b0, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    nChecks++; if (psel_o !== 5'b00001 || penable_o !== 1'b1) $display("FAIL rm_in_access got %b/%b exp 00001/1", psel_o, penable_o); else nPass++;
    #2 rst_n = 1'b0;
    #1;
    nChecks++; if (psel_o !== 5'b0 || penable_o !== 1'b0) $display("FAIL rm_async_drop got %b/%b exp 0/0", psel_o, penable_o); else nPass++;
    nChecks++; if (req_ready_o !== 1'b1 || timeout_cnt_o !== 8'h0) $display("FAIL rm_reset_vals got %b/%0d exp 1/0", req_ready_o, timeout_cnt_o); else nPass++;
    modelTo = 0;
    sawValid = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (rsp_valid_o) sawValid = 1;
    end
    #2 rst_n = 1'b1;
    run_txn(32'h2000_4100, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h7777_8888, 0);
    nChecks++; if (sawValid !== 1'b0) $display("FAIL rm_no_rsp got %b exp 0", sawValid); else nPass++;
    nChecks++; if (obsReady0 !== 1'b1 || obsCyc !== 3) $display("FAIL rm_first_req got %b/%0d exp 1/3", obsReady0, obsCyc); else nPass++;
    nChecks++; if (obsRdata !== 32'h7777_8888 || obsErr !== 1'b0) $display("FAIL rm_first_rsp got %h/%b exp 77778888/0", obsRdata, obsErr); else nPass++;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_read_zero_wait();
    test_write_wait();
    test_unmapped();
    test_slverr_hold();
    test_random();
    test_timeout();
    test_timeout_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
